// File: rtl/flags_pkg.sv
// Shared types and helpers for the condition-flag pipeline.
// Slot layout is {valid, mask, data}; flag bit order is N,Z,V,C from MSB.
package flags_pkg;

    localparam int NZVC_W    = 4;
    localparam int FLAG_N    = 3;
    localparam int FLAG_Z    = 2;
    localparam int FLAG_V    = 1;
    localparam int FLAG_C    = 0;
    localparam int MAX_FLAGS = 32;

    typedef struct packed {
        logic              valid;
        logic [NZVC_W-1:0] mask;
        logic [NZVC_W-1:0] data;
    } flag_slot_t;

    // Masked merge; callers zero-extend narrower flag vectors into MAX_FLAGS bits.
    function automatic logic [MAX_FLAGS-1:0] merge_flags(
        input logic [MAX_FLAGS-1:0] old_f,
        input logic [MAX_FLAGS-1:0] mask,
        input logic [MAX_FLAGS-1:0] new_f
    );
        return (old_f & ~mask) | (new_f & mask);
    endfunction

endpackage

// File: rtl/flag_slot.sv
// One in-flight flag slot: loads d on enable, drops valid on kill.
// Bit layout {valid, mask[W-1:0], data[W-1:0]}, valid at the MSB.
module flag_slot
    import flags_pkg::*;
#(
    parameter int W = NZVC_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         kill,
    input  logic [2*W:0] d,
    output logic [2*W:0] q
);

    logic [2*W:0] slot_q;

    // A killed slot keeps its mask/data but can never commit or forward.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q <= '0;
        end else if (enable) begin
            slot_q <= {d[2*W] & ~kill, d[2*W-1:0]};
        end else if (kill) begin
            slot_q[2*W] <= 1'b0;
        end
    end

    assign q = slot_q;

endmodule

// File: rtl/flag_pipe_unit.sv
// Condition-flag pipeline: DEPTH in-flight slots from EX to commit plus forwarded view.
// Optional macro FLAG_FWD_EN enables the forwarding priority chain on fwd_flags.
module flag_pipe_unit
    import flags_pkg::*;
#(
    parameter int NUM_FLAGS = 4,
    parameter int DEPTH     = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       set_flags,
    input  logic [NUM_FLAGS-1:0]       set_mask,
    input  logic [NUM_FLAGS-1:0]       flags_in,
    input  logic                       stall,
    input  logic                       flush,
    output logic [NUM_FLAGS-1:0]       curr_flags,
    output logic [NUM_FLAGS-1:0]       fwd_flags,
    output logic [$clog2(DEPTH+1)-1:0] pending_cnt,
    output logic                       pending
);

    localparam int SW = 2*NUM_FLAGS + 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0][SW-1:0] slot_d, slot_q;
    logic [NUM_FLAGS-1:0]     curr_d, curr_q;
    logic [SW-1:0]            oldest;
    logic                     advance;

    assign advance   = ~stall;
    assign slot_d[0] = {set_flags, set_mask, flags_in};

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        if (k > 0) begin : g_chain
            assign slot_d[k] = slot_q[k-1];
        end
        flag_slot #(.W(NUM_FLAGS)) u_slot (
            .clk    (clk),
            .reset  (reset),
            .enable (advance),
            .kill   (flush),
            .d      (slot_d[k]),
            .q      (slot_q[k])
        );
    end

    assign oldest = slot_q[DEPTH-1];

    // The oldest slot is past the flush point, so flush does not block its commit.
    always_comb begin
        curr_d = curr_q;
        if (advance && oldest[SW-1]) begin
            curr_d = NUM_FLAGS'(merge_flags(MAX_FLAGS'(curr_q),
                                            MAX_FLAGS'(oldest[2*NUM_FLAGS-1:NUM_FLAGS]),
                                            MAX_FLAGS'(oldest[NUM_FLAGS-1:0])));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            curr_q <= '0;
        end else begin
            curr_q <= curr_d;
        end
    end

    always_comb begin
        pending_cnt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            pending_cnt = pending_cnt + CW'(slot_q[k][SW-1]);
        end
    end

    assign pending    = (pending_cnt != '0);
    assign curr_flags = curr_q;

`ifdef FLAG_FWD_EN
    // Walk oldest to youngest so younger slots overwrite; live EX request wins last.
    always_comb begin
        fwd_flags = curr_q;
        for (int k = DEPTH-1; k >= 0; k--) begin
            for (int i = 0; i < NUM_FLAGS; i++) begin
                if (slot_q[k][SW-1] && slot_q[k][NUM_FLAGS+i]) begin
                    fwd_flags[i] = slot_q[k][i];
                end
            end
        end
        for (int i = 0; i < NUM_FLAGS; i++) begin
            if (set_flags && set_mask[i] && !flush && !stall) begin
                fwd_flags[i] = flags_in[i];
            end
        end
    end
`else
    assign fwd_flags = curr_q;
`endif

endmodule

// File: tb/tb_flag_pipe_unit.sv
// Self-checking bench: DEPTH=1,2,3 instances share stimulus and are compared each
// cycle against a per-depth behavioural model; honours FLAG_FWD_EN when defined.
module tb_flag_pipe_unit;
    import flags_pkg::*;

    logic       clk = 1'b0;
    logic       reset, set_flags, stall, flush;
    logic [3:0] set_mask, flags_in;

    logic [3:0] curr1, curr2, curr3, fwd1, fwd2, fwd3;
    logic [0:0] cnt1;
    logic [1:0] cnt2, cnt3;
    logic       pend1, pend2, pend3;

    int n_chk  = 0;
    int n_fail = 0;
    bit do_chk = 1'b0;

    flag_slot_t ms   [3][8];
    logic [3:0] mcur [3];

    always #5 clk = ~clk;

    flag_pipe_unit #(.NUM_FLAGS(4), .DEPTH(1)) u_d1 (
        .clk(clk), .reset(reset), .set_flags(set_flags), .set_mask(set_mask),
        .flags_in(flags_in), .stall(stall), .flush(flush), .curr_flags(curr1),
        .fwd_flags(fwd1), .pending_cnt(cnt1), .pending(pend1));
    flag_pipe_unit #(.NUM_FLAGS(4), .DEPTH(2)) u_d2 (
        .clk(clk), .reset(reset), .set_flags(set_flags), .set_mask(set_mask),
        .flags_in(flags_in), .stall(stall), .flush(flush), .curr_flags(curr2),
        .fwd_flags(fwd2), .pending_cnt(cnt2), .pending(pend2));
    flag_pipe_unit #(.NUM_FLAGS(4), .DEPTH(3)) u_d3 (
        .clk(clk), .reset(reset), .set_flags(set_flags), .set_mask(set_mask),
        .flags_in(flags_in), .stall(stall), .flush(flush), .curr_flags(curr3),
        .fwd_flags(fwd3), .pending_cnt(cnt3), .pending(pend3));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_cnt(input int d);
        int c = 0;
        for (int k = 0; k <= d; k++) c += int'(ms[d][k].valid);
        return c;
    endfunction

    // Forwarded view from the rules: live request, else youngest valid masked slot, else arch.
    function automatic logic [3:0] exp_fwd(input int d);
        logic [3:0] f;
        f = mcur[d];
`ifdef FLAG_FWD_EN
        for (int i = 0; i < 4; i++) begin
            bit found = 1'b0;
            if (set_flags && set_mask[i] && !flush && !stall) begin
                f[i] = flags_in[i];
                found = 1'b1;
            end
            for (int k = 0; k <= d; k++) begin
                if (!found && ms[d][k].valid && ms[d][k].mask[i]) begin
                    f[i] = ms[d][k].data[i];
                    found = 1'b1;
                end
            end
        end
`endif
        return f;
    endfunction

    task automatic model_step();
        for (int d = 0; d < 3; d++) begin
            if (reset) begin
                for (int k = 0; k < 8; k++) ms[d][k] = '0;
                mcur[d] = 4'h0;
            end else if (!stall) begin
                if (ms[d][d].valid)
                    mcur[d] = (mcur[d] & ~ms[d][d].mask) | (ms[d][d].data & ms[d][d].mask);
                for (int k = d; k >= 1; k--) begin
                    ms[d][k] = ms[d][k-1];
                    if (flush) ms[d][k].valid = 1'b0;
                end
                ms[d][0].valid = set_flags & ~flush;
                ms[d][0].mask  = set_mask;
                ms[d][0].data  = flags_in;
            end else if (flush) begin
                for (int k = 0; k <= d; k++) ms[d][k].valid = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        logic [3:0] cur [3];
        logic [3:0] fw  [3];
        int         cn  [3];
        logic       pd  [3];
        cur = '{curr1, curr2, curr3};
        fw  = '{fwd1, fwd2, fwd3};
        cn  = '{int'(cnt1), int'(cnt2), int'(cnt3)};
        pd  = '{pend1, pend2, pend3};
        for (int d = 0; d < 3; d++) begin
            check($sformatf("d%0d_curr", d+1), 32'(cur[d]), 32'(mcur[d]));
            check($sformatf("d%0d_fwd", d+1),  32'(fw[d]),  32'(exp_fwd(d)));
            check($sformatf("d%0d_cnt", d+1),  32'(cn[d]),  32'(exp_cnt(d)));
            check($sformatf("d%0d_pend", d+1), 32'(pd[d]),  32'(exp_cnt(d) != 0));
        end
    endtask

    task automatic step(input bit rst, input bit sf, input logic [3:0] sm, input logic [3:0] fi,
                        input bit st, input bit fl);
        @(negedge clk);
        reset = rst; set_flags = sf; set_mask = sm; flags_in = fi; stall = st; flush = fl;
        #1;
        if (do_chk) check_all();
        @(posedge clk);
        model_step();
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            mcur[d] = 4'h0;
            for (int k = 0; k < 8; k++) ms[d][k] = '0;
        end
        step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        do_chk = 1'b1;
        step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("rst_curr", 32'(curr2), 32'h0);
        check("rst_cnt",  32'(cnt3),  32'h0);

        // full-mask request held for two cycles
        step(1'b0, 1'b1, 4'hF, 4'hA, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'hF, 4'hA, 1'b0, 1'b0);
        idle(4);
        check("full_commit", 32'(curr2), 32'hA);
        step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        // partial merge N then C
        step(1'b0, 1'b1, 4'h8, 4'hF, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'h1, 4'h7, 1'b0, 1'b0);
        idle(4);
        check("merge_commit", 32'(curr3), 32'h9);
        // stall with held request
        step(1'b0, 1'b1, 4'hF, 4'h5, 1'b0, 1'b0);
        for (int j = 0; j < 3; j++) step(1'b0, 1'b1, 4'hF, 4'h5, 1'b1, 1'b0);
        idle(4);
        // flush with two pending plus incoming
        step(1'b0, 1'b1, 4'hF, 4'h3, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'hF, 4'hC, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'hF, 4'hF, 1'b0, 1'b1);
        idle(4);
        // flush at commit slot, without and with stall
        step(1'b0, 1'b1, 4'hF, 4'h4, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'hF, 4'h9, 1'b0, 1'b1);
        step(1'b0, 1'b1, 4'hF, 4'h2, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'hF, 4'h6, 1'b1, 1'b1);
        idle(4);
        // fill pipeline then reset mid-operation
        for (int j = 0; j < 3; j++) step(1'b0, 1'b1, 4'hF, 4'(j + 5), 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'hF, 4'hE, 1'b0, 1'b0);
        idle(4);

        for (int j = 0; j < 1500; j++) begin
            step(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1,
                 4'($urandom), 4'($urandom),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
        end
        @(negedge clk);
        check_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
